stream_packer: RTL
==================

Name: stream_packer

Overview:
- Upstream neighbour of the stream register slice.
- Accepts narrow IN_W-bit beats on a valid/ready stream with a packet-end flag. Packs RATIO beats, lane 0 first, into one OUT_W = IN_W*RATIO word.
- Presents each packed word from a registered valid/ready output that drives the slice's up_valid/up_data/up_ready directly.
- A packet-end beat flushes a partial word early, with a lane count.

Parameters:
- IN_W, 4: width of one input beat (lane).
- RATIO, 4: lanes per output word; must be >= 2. OUT_W = IN_W*RATIO (16 at defaults, matching the slice's DW).
- CW, $clog2(RATIO+1): width of the lane-count output (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, ACTIVE-LOW (0 = reset), sampled on posedge clk.
- up_valid  input  1  input beat valid.
- up_data  input  IN_W  input beat.
- up_last  input  1  beat is final of packet; qualified by up_valid.
- up_ready  output  1  input beat accepted when up_valid && up_ready.
- down_ready  input  1  consumer ready.
- down_valid  output  1  packed word valid (registered).
- down_data  output  OUT_W  packed word (registered); lane k = bits [k*IN_W +: IN_W].
- down_count  output  CW  number of populated lanes, 1..RATIO (registered).
- down_last  output  1  word ends a packet (registered).

Behaviour:
Internal state:
- acc: OUT_W accumulator.
- cnt: lane index 0..RATIO-1.

Ready:
- up_ready = !down_valid || down_ready, combinational.
- Does not depend on up_valid, up_data or up_last.

On an accepted beat (up_valid && up_ready):
- The beat is written into lane cnt.
- Completing case (cnt == RATIO-1, or up_last == 1):
  - down_data <= acc with the beat in lane cnt, lanes above cnt forced to 0.
  - down_count <= cnt+1; down_last <= up_last; down_valid <= 1.
  - acc <= 0; cnt <= 0.
- Otherwise: acc lane cnt <= up_data; cnt <= cnt+1; output registers unchanged apart from the release rule below.

Output release:
- If down_valid && down_ready and no completing beat is accepted in the same cycle: down_valid <= 0.
- down_data, down_count and down_last may keep stale values while down_valid is 0.

Timing:
- Latency: down_valid rises on the clock edge following the completing input handshake, i.e. 1 cycle.
- Throughput: one input beat per cycle sustained while down_ready stays 1, with no bubbles.
- Simultaneous output drain and completing beat in one cycle: the new word replaces the old and down_valid stays 1.

Backpressure:
- While down_valid && !down_ready, up_ready = 0. All input stalls, including non-completing beats.
- down_valid, down_data, down_count and down_last hold stable until accepted.

Packets:
- up_last on the first beat gives down_count = 1, down_last = 1, and only lane 0 is non-zero.
- up_last on lane RATIO-1 gives down_count = RATIO, down_last = 1.
- Exactly RATIO beats without up_last gives down_count = RATIO, down_last = 0; packing continues into the next word.
- No zero-length words are ever emitted.

Reset (rst == 0):
- Outputs: down_valid = 0, down_data = 0, down_count = 0, down_last = 0.
- Internal: acc = 0, cnt = 0.
- up_ready is 1 after the first clock edge in reset.
- Reset mid-packet discards the partial accumulator and any unaccepted output word.
- After reset, packing restarts at lane 0.

Test Plan:
1. RATIO=4, IN_W=4, down_ready=1; beats 0x1,0x2,0x3,0x4, none last -> down_data=0x4321, count=4, last=0, down_valid high exactly 1 cycle after 4th handshake.
2. Beats 0xA,0xB with last on 0xB -> down_data=0x00BA, count=2, last=1. Next beat 0xC with last -> 0x000C, count=1, last=1.
3. Backpressure: after word 0x4321 emitted, hold down_ready=0 for 5 cycles while up_valid=1 -> up_ready=0 throughout and outputs stable. Raise down_ready -> word accepted; next 4 beats 0x5..0x8 yield 0x8765.
4. Continuous: 12 beats 0x0..0xB at full rate, down_ready=1 -> words 0x3210, 0x7654, 0xBA98, no input stall cycles.
5. Reset: feed 0x1,0x2 then pull rst low 1 cycle -> down_valid=0, down_data=0. Then beats 0x9 (last) -> 0x0009, count=1 (no 0x1/0x2 residue).
6. Drain plus completion same cycle: word pending with down_ready=1 while the 4th beat of the next word arrives -> down_valid stays 1, new data presented on the next cycle.

Source files
------------

// File: rtl/stream_packer_if.sv
// Bundles the narrow input stream and the packed output stream of stream_packer.
// The slave modport is the packer's view; master is the producer/consumer side.
interface stream_packer_if #(
    parameter int IN_W  = 4,
    parameter int RATIO = 4
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);

    logic             up_valid;
    logic [IN_W-1:0]  up_data;
    logic             up_last;
    logic             up_ready;

    logic             down_ready;
    logic             down_valid;
    logic [OUT_W-1:0] down_data;
    logic [CW-1:0]    down_count;
    logic             down_last;

    modport master (
        output up_valid, up_data, up_last, down_ready,
        input  up_ready, down_valid, down_data, down_count, down_last
    );

    modport slave (
        input  up_valid, up_data, up_last, down_ready,
        output up_ready, down_valid, down_data, down_count, down_last
    );
endinterface

// File: rtl/stream_packer.sv
// Packs RATIO narrow beats (lane 0 first) into one wide word on a registered
// valid/ready output; a packet-end beat flushes a partial word with its lane count.
module stream_packer #(
    parameter int IN_W  = 4,
    parameter int RATIO = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_packer_if.slave bus
);
    localparam int OUT_W = IN_W * RATIO;
    localparam int CW    = $clog2(RATIO + 1);
    localparam int LW    = $clog2(RATIO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic [OUT_W-1:0] acc_q, acc_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             down_valid_q, down_valid_d;
    logic [OUT_W-1:0] down_data_q, down_data_d;
    logic [CW-1:0]    down_count_q, down_count_d;
    logic             down_last_q, down_last_d;

    logic             up_ready;
    logic             accept;
    logic             completing;
    logic [OUT_W-1:0] packed_word;
    logic [OUT_W-1:0] acc_written;

    // Input may only advance when the output register is free or draining this cycle.
    assign up_ready   = !down_valid_q || bus.down_ready;
    assign accept     = bus.up_valid && up_ready;
    assign completing = bus.up_last || (cnt_q == LAST_LANE);

    genvar gi;
    generate
        for (gi = 0; gi < RATIO; gi++) begin : g_lane
            localparam logic [LW-1:0] LANE = LW'(gi);
            // Lanes above the current index are forced to zero on a flush.
            assign packed_word[gi*IN_W +: IN_W] =
                (LANE < cnt_q)  ? acc_q[gi*IN_W +: IN_W] :
                (LANE == cnt_q) ? bus.up_data            :
                                  {IN_W{1'b0}};
            assign acc_written[gi*IN_W +: IN_W] =
                (LANE == cnt_q) ? bus.up_data : acc_q[gi*IN_W +: IN_W];
        end
    endgenerate

    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        down_valid_d = down_valid_q;
        down_data_d  = down_data_q;
        down_count_d = down_count_q;
        down_last_d  = down_last_q;

        if (down_valid_q && bus.down_ready) begin
            down_valid_d = 1'b0;
        end

        if (accept) begin
            if (completing) begin
                down_data_d  = packed_word;
                down_count_d = CW'(cnt_q) + CW'(1);
                down_last_d  = bus.up_last;
                down_valid_d = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
            end else begin
                acc_d = acc_written;
                cnt_d = cnt_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_count_q <= '0;
            down_last_q  <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_count_q <= down_count_d;
            down_last_q  <= down_last_d;
        end
    end

    assign bus.up_ready   = up_ready;
    assign bus.down_valid = down_valid_q;
    assign bus.down_data  = down_data_q;
    assign bus.down_count = down_count_q;
    assign bus.down_last  = down_last_q;
endmodule
